bellek_hakemi: RTL

//  Arbitrates one shared main-memory port between L1 instruction-cache refills (l1b) and
//  L1 data-cache refills/writes (l1v). Sits between the two L1 caches and the memory bus.

---
 rtl/bellek_hakemi_pkg.sv | 14 +
 rtl/bellek_hakemi.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bellek_hakemi_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transaction owners.
package bellek_hakemi_pkg;

    typedef logic [1:0] durum_t;
    typedef logic       sahip_t;

    localparam durum_t BOSTA  = 2'd0;
    localparam durum_t HIZMET = 2'd1;
    localparam durum_t BITIR  = 2'd2;

    localparam sahip_t SAHIP_L1B = 1'b0;
    localparam sahip_t SAHIP_L1V = 1'b1;

endpackage

// File: rtl/bellek_hakemi.sv
// Round-robin arbiter granting one shared main-memory port to the L1 instruction
// and L1 data caches, one burst or single-beat transaction at a time.
module bellek_hakemi
    import bellek_hakemi_pkg::*;
#(
    parameter int BURST_UZUNLUK = 4,
    parameter int VERI_BIT      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  l1b_istek_i,
    input  logic [31:0]           l1b_adr_i,
    output logic [VERI_BIT-1:0]   l1b_veri_o,
    output logic                  l1b_gecerli_o,
    output logic                  l1b_son_o,

    input  logic                  l1v_istek_i,
    input  logic                  l1v_yaz_i,
    input  logic                  l1v_tek_i,
    input  logic [31:0]           l1v_adr_i,
    input  logic [VERI_BIT/8-1:0] l1v_maske_i,
    input  logic [VERI_BIT-1:0]   l1v_veri_i,
    output logic                  l1v_veri_al_o,
    output logic [VERI_BIT-1:0]   l1v_veri_o,
    output logic                  l1v_gecerli_o,
    output logic                  l1v_son_o,

    output logic                  bel_istek_o,
    output logic                  bel_yaz_o,
    output logic [31:0]           bel_adr_o,
    output logic [VERI_BIT/8-1:0] bel_maske_o,
    output logic [VERI_BIT-1:0]   bel_veri_o,
    input  logic [VERI_BIT-1:0]   bel_veri_i,
    input  logic                  bel_gecerli_i
);

    localparam int SW  = $clog2(BURST_UZUNLUK);
    localparam int OFS = SW + 2;
    localparam int MW  = VERI_BIT / 8;
    localparam logic [31:0]   HIZA_MASKE = ~((32'd1 << OFS) - 32'd1);
    localparam logic [SW-1:0] SON_SAYAC  = SW'(BURST_UZUNLUK - 1);

    durum_t          durum;
    sahip_t          sahip;
    sahip_t          son_sahip;
    logic            yaz_r;
    logic            tek_r;
    logic [31:0]     taban;
    logic [MW-1:0]   maske_r;
    logic [SW-1:0]   sayac;

    logic            hizmet;
    logic            beat;
    logic            son_beat;
    logic            l1v_secildi;

    always_comb begin
        hizmet      = (durum == HIZMET);
        beat        = hizmet && bel_gecerli_i;
        son_beat    = tek_r || (sayac == SON_SAYAC);
        // On a tie the side that was not served last wins.
        l1v_secildi = l1v_istek_i && (!l1b_istek_i || son_sahip == SAHIP_L1B);
    end

    always_comb begin
        bel_istek_o   = hizmet;
        bel_yaz_o     = hizmet && yaz_r;
        bel_adr_o     = hizmet ? taban + {{(32-OFS){1'b0}}, sayac, 2'b00} : '0;
        bel_maske_o   = hizmet ? maske_r : '0;
        bel_veri_o    = (hizmet && yaz_r) ? l1v_veri_i : '0;
        l1v_veri_al_o = beat && yaz_r;
        l1b_son_o     = (durum == BITIR) && (sahip == SAHIP_L1B);
        l1v_son_o     = (durum == BITIR) && (sahip == SAHIP_L1V);
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order inside the block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum         <= BOSTA;
            sahip         <= SAHIP_L1B;
            son_sahip     <= SAHIP_L1B;
            yaz_r         <= 1'b0;
            tek_r         <= 1'b0;
            taban         <= '0;
            maske_r       <= '0;
            sayac         <= '0;
            l1b_gecerli_o <= 1'b0;
            l1v_gecerli_o <= 1'b0;
            l1b_veri_o    <= '0;
            l1v_veri_o    <= '0;
        end else begin
            l1b_gecerli_o <= beat && !yaz_r && (sahip == SAHIP_L1B);
            l1v_gecerli_o <= beat && !yaz_r && (sahip == SAHIP_L1V);
            if (beat && !yaz_r) begin
                if (sahip == SAHIP_L1B) l1b_veri_o <= bel_veri_i;
                else                    l1v_veri_o <= bel_veri_i;
            end

            case (durum)
                BOSTA: begin
                    if (l1b_istek_i || l1v_istek_i) begin
                        durum <= HIZMET;
                        sayac <= '0;
                        if (l1v_secildi) begin
                            sahip   <= SAHIP_L1V;
                            yaz_r   <= l1v_yaz_i;
                            tek_r   <= l1v_tek_i;
                            taban   <= l1v_tek_i ? {l1v_adr_i[31:2], 2'b00}
                                                 : (l1v_adr_i & HIZA_MASKE);
                            maske_r <= l1v_yaz_i ? l1v_maske_i : '1;
                        end else begin
                            sahip   <= SAHIP_L1B;
                            yaz_r   <= 1'b0;
                            tek_r   <= 1'b0;
                            taban   <= l1b_adr_i & HIZA_MASKE;
                            maske_r <= '1;
                        end
                    end
                end
                HIZMET: begin
                    if (bel_gecerli_i) begin
                        if (son_beat) begin
                            durum     <= BITIR;
                            son_sahip <= sahip;
                            sayac     <= '0;
                        end else begin
                            sayac <= sayac + SW'(1);
                        end
                    end
                end
                BITIR:   durum <= BOSTA;
                default: durum <= BOSTA;
            endcase
        end
    end

endmodule
